mem_line_responder: RTL

MEM_LINE_RESPONDER -- requirements
Module: mem_line_responder

---
 rtl/mem_line_responder.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/mem_line_responder.sv
// Line-wide memory responder: in-order request queue feeding a
// fixed-latency access FSM with a held response until consumed.
module mem_line_responder #(
  parameter int LINE_WIDTH  = 128,
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH_LINES = 256,
  parameter int LATENCY     = 4,
  parameter int QDEPTH      = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [LINE_WIDTH-1:0]   req_wdata,
  input  logic [LINE_WIDTH/8-1:0] req_be,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [LINE_WIDTH-1:0]   resp_data,
  output logic                    resp_write,
  output logic                    resp_err,
  output logic                    busy
);

  localparam int BW  = LINE_WIDTH / 8;
  localparam int OFF = $clog2(BW);
  localparam int PW  = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int IW  = (DEPTH_LINES > 1) ? $clog2(DEPTH_LINES) : 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  logic [LINE_WIDTH-1:0] lines [DEPTH_LINES];

  logic                  q_write [QDEPTH];
  logic [ADDR_WIDTH-1:0] q_addr  [QDEPTH];
  logic [LINE_WIDTH-1:0] q_wdata [QDEPTH];
  logic [BW-1:0]         q_be    [QDEPTH];

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic          push;
  logic          pop;
  logic          q_nempty;

  state_t state;
  state_t state_nxt;
  logic [3:0] cnt;
  logic       access;

  logic                  cur_write;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [LINE_WIDTH-1:0] cur_wdata;
  logic [BW-1:0]         cur_be;
  logic [ADDR_WIDTH-1:0] cur_line;
  logic [IW-1:0]         cur_idx;
  logic                  in_range;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(QDEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign q_nempty  = (count != '0);
  assign req_ready = (count != (PW+1)'(QDEPTH));
  assign push      = req_valid && req_ready;

  assign cur_line = cur_addr >> OFF;
  assign cur_idx  = cur_line[IW-1:0];
  assign in_range = (cur_line < ADDR_WIDTH'(DEPTH_LINES));
  assign access   = (state == WAIT) && (cnt == '0);

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      q_write[wr_ptr] <= req_write;
      q_addr[wr_ptr]  <= req_addr;
      q_wdata[wr_ptr] <= req_wdata;
      q_be[wr_ptr]    <= req_be;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      resp_data  <= '0;
      resp_write <= 1'b0;
      resp_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (pop)
        cnt <= 4'(LATENCY - 1);
      else if (state == WAIT && cnt != '0)
        cnt <= cnt - 4'd1;
      if (access) begin
        resp_write <= cur_write;
        resp_err   <= !in_range;
        resp_data  <= (cur_write || !in_range) ? '0 : lines[cur_idx];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (pop) begin
      cur_write <= q_write[rd_ptr];
      cur_addr  <= q_addr[rd_ptr];
      cur_wdata <= q_wdata[rd_ptr];
      cur_be    <= q_be[rd_ptr];
    end
  end

  // Storage is never reset; a write aborted by reset must not land.
  always_ff @(posedge clock) begin
    if (!reset && access && cur_write && in_range) begin
      for (int b = 0; b < BW; b++) begin
        if (cur_be[b])
          lines[cur_idx][b*8 +: 8] <= cur_wdata[b*8 +: 8];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    unique case (state)
      IDLE: begin
        if (q_nempty) begin
          pop       = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (cnt == '0) state_nxt = RESP;
      end
      RESP: begin
        if (resp_ready) begin
          if (q_nempty) begin
            pop       = 1'b1;
            state_nxt = WAIT;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    resp_valid = (state == RESP);
    busy       = q_nempty || (state != IDLE);
  end

endmodule
